cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_seq_pkg.sv | 19 +
 rtl/cpu_sequencer_sat_counter.sv | 27 ++
 rtl/cpu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_pkg
//   Shared definitions for the CPU sequencer slice.
//   - seq_state_e : sequencer state encoding (FETCH / EXEC / HALT)
//   - EXEC_MAX_DEF: default maximum execute cycles per instruction
//   - CNT_W_DEF   : default performance counter width
// ---------------------------------------------------------------------------
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'd0,
        SEQ_EXEC  = 2'd1,
        SEQ_HALT  = 2'd2
    } seq_state_e;

    localparam int EXEC_MAX_DEF = 2;
    localparam int CNT_W_DEF    = 16;

endpackage : cpu_seq_pkg

// File: rtl/cpu_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     reset - synchronous active-high clear
//     inc   - count enable for this cycle
//     count - current count value (WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : sat_counter

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Instruction sequencer: FETCH -> EXEC (1..EXEC_MAX cycles) -> FETCH,
//   with an optional HALT state entered when halt_req is seen on the
//   retiring cycle of an instruction.
//
//   Parameters:
//     EXEC_MAX - maximum execute cycles per instruction (1..8)
//     CNT_W    - performance counter width
//
//   Ports:
//     clk       - clock, rising edge
//     reset     - synchronous active-high reset (back to FETCH)
//     stall     - hold current FETCH/EXEC state (ignored in HALT)
//     exec_len  - execute length of the instruction being fetched
//     halt_req  - halt after the instruction retiring this cycle
//     resume    - leave HALT
//     fetch     - high in FETCH
//     exec      - one-hot execute cycle index, zero outside EXEC
//     halted    - high in HALT
//     phase     - 0 in FETCH, k+1 in execute cycle k, EXEC_MAX+1 in HALT
//     retire    - final unstalled execute cycle of an instruction
//     cycle_cnt - non-HALT cycle count (saturating)
//     instr_cnt - retired instruction count (saturating)
//
//   Build option:
//     CPU_SEQ_PERF_COUNT_EN - when defined, cycle_cnt/instr_cnt are live
//     saturating counters; otherwise they are tied to zero and no counter
//     registers exist.
// ---------------------------------------------------------------------------
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int EXEC_MAX = EXEC_MAX_DEF,
    parameter  int CNT_W    = CNT_W_DEF,
    localparam int LEN_W    = $clog2(EXEC_MAX + 1),
    localparam int PH_W     = $clog2(EXEC_MAX + 2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [LEN_W-1:0]    exec_len,
    input  logic                halt_req,
    input  logic                resume,
    output logic                fetch,
    output logic [EXEC_MAX-1:0] exec,
    output logic                halted,
    output logic [PH_W-1:0]     phase,
    output logic                retire,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_lat;
    logic             last_exec;

    // Clamp the requested length into 1..EXEC_MAX before latching.
    always_comb begin
        len_lat = exec_len;
        if (exec_len == '0) begin
            len_lat = LEN_W'(1);
        end else if (exec_len > LEN_W'(EXEC_MAX)) begin
            len_lat = LEN_W'(EXEC_MAX);
        end
    end

    // k never exceeds EXEC_MAX-1, so k+1 fits in LEN_W bits.
    assign last_exec = ((k_q + LEN_W'(1)) == len_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEQ_FETCH;
            k_q     <= '0;
            len_q   <= LEN_W'(1);
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
        end
    end

    // ---------------- next state / retire ----------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        retire  = 1'b0;
        unique case (state_q)
            SEQ_FETCH: begin
                if (!stall) begin
                    len_d   = len_lat;
                    k_d     = '0;
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (!stall) begin
                    if (last_exec) begin
                        // A reset on this edge aborts the instruction, so
                        // it does not count as retired.
                        retire  = !reset;
                        k_d     = '0;
                        state_d = halt_req ? SEQ_HALT : SEQ_FETCH;
                    end else begin
                        k_d = k_q + LEN_W'(1);
                    end
                end
            end
            SEQ_HALT: begin
                if (resume) begin
                    state_d = SEQ_FETCH;
                end
            end
            default: begin
                state_d = SEQ_FETCH;
                k_d     = '0;
                len_d   = LEN_W'(1);
            end
        endcase
    end

    // ---------------- Moore outputs ----------------
    always_comb begin
        fetch  = 1'b0;
        halted = 1'b0;
        exec   = '0;
        phase  = '0;
        unique case (state_q)
            SEQ_FETCH: begin
                fetch = 1'b1;
            end
            SEQ_EXEC: begin
                exec  = EXEC_MAX'(1) << k_q;
                phase = PH_W'(k_q) + PH_W'(1);
            end
            SEQ_HALT: begin
                halted = 1'b1;
                phase  = PH_W'(EXEC_MAX + 1);
            end
            default: begin
                fetch = 1'b0;
            end
        endcase
    end

    // ---------------- performance counters ----------------
`ifdef CPU_SEQ_PERF_COUNT_EN
    logic cyc_inc;
    assign cyc_inc = (state_q != SEQ_HALT);

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cyc_inc),
        .count (cycle_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (instr_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule : cpu_sequencer

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//   Two sequencers run side by side on shared stimulus:
//     inst 0: EXEC_MAX=2, CNT_W=16
//     inst 1: EXEC_MAX=4, CNT_W=4
//   A phase-number reference model tracks each one; directed scenarios
//   also compare against hand-derived constant sequences.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst, stl, hreq, res;
    logic [2:0] el;

    logic       fetch_a, halted_a, retire_a;
    logic [1:0] exec_a;
    logic [1:0] phase_a;
    logic [15:0] cyc_a, ins_a;

    logic       fetch_b, halted_b, retire_b;
    logic [3:0] exec_b;
    logic [2:0] phase_b;
    logic [3:0] cyc_b, ins_b;

    int checks   = 0;
    int failures = 0;

    cpu_sequencer #(.EXEC_MAX(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst), .stall(stl), .exec_len(el[1:0]),
        .halt_req(hreq), .resume(res), .fetch(fetch_a), .exec(exec_a),
        .halted(halted_a), .phase(phase_a), .retire(retire_a),
        .cycle_cnt(cyc_a), .instr_cnt(ins_a)
    );

    cpu_sequencer #(.EXEC_MAX(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst), .stall(stl), .exec_len(el),
        .halt_req(hreq), .resume(res), .fetch(fetch_b), .exec(exec_b),
        .halted(halted_b), .phase(phase_b), .retire(retire_b),
        .cycle_cnt(cyc_b), .instr_cnt(ins_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each instance is a single phase number: 0 = fetch, 1..L = execute
    // cycles of the current instruction, EM+1 = halted.
    int m_ph[2]  = '{0, 0};
    int m_len[2] = '{1, 1};
    int m_cyc[2] = '{0, 0};
    int m_ins[2] = '{0, 0};

    function automatic int em(int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int cmax(int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    function automatic int req_len(int i);
        int v;
        v = (i == 0) ? int'(el[1:0]) : int'(el);
        if (v == 0) return 1;
        if (v > em(i)) return em(i);
        return v;
    endfunction

    function automatic bit m_retire(int i);
        return !rst && !stl && m_ph[i] >= 1 && m_ph[i] <= em(i) && m_ph[i] == m_len[i];
    endfunction

    task automatic model_edge();
        bit r[2];
        for (int i = 0; i < 2; i++) r[i] = m_retire(i);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ph[i] = 0; m_len[i] = 1; m_cyc[i] = 0; m_ins[i] = 0;
            end else begin
                if (m_ph[i] != em(i) + 1 && m_cyc[i] < cmax(i)) m_cyc[i]++;
                if (r[i] && m_ins[i] < cmax(i)) m_ins[i]++;
                if (m_ph[i] == 0) begin
                    if (!stl) begin m_len[i] = req_len(i); m_ph[i] = 1; end
                end else if (m_ph[i] <= em(i)) begin
                    if (!stl) begin
                        if (r[i]) m_ph[i] = hreq ? em(i) + 1 : 0;
                        else      m_ph[i]++;
                    end
                end else if (res) begin
                    m_ph[i] = 0;
                end
            end
        end
    endtask

    // Packed view: {fetch, halted, retire, exec[7:0], phase[7:0], cyc[15:0], ins[15:0]}
    function automatic logic [50:0] exp_vec(int i);
        logic [7:0]  ex;
        logic [15:0] c, n;
        ex = '0;
        if (m_ph[i] >= 1 && m_ph[i] <= em(i)) ex = 8'(1 << (m_ph[i] - 1));
`ifdef CPU_SEQ_PERF_COUNT_EN
        c = 16'(m_cyc[i]); n = 16'(m_ins[i]);
`else
        c = '0; n = '0;
`endif
        return {m_ph[i] == 0, m_ph[i] == em(i) + 1, m_retire(i), ex, 8'(m_ph[i]), c, n};
    endfunction

    function automatic logic [50:0] obs_vec(int i);
        if (i == 0)
            return {fetch_a, halted_a, retire_a, 8'(exec_a), 8'(phase_a), cyc_a, ins_a};
        return {fetch_b, halted_b, retire_b, 8'(exec_b), 8'(phase_b), 16'(cyc_b), 16'(ins_b)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stl = 1'b0; hreq = 1'b0; res = 1'b0; el = 3'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        stl = 1'b1; hreq = 1'b1;
        rst = 1'b1;
        step(); step();
        idle_inputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== {1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 16'h0, 16'h0}) begin
                failures++;
                $display("FAIL reset_state inst=%0d got=%h want=%h", i, obs_vec(i),
                         {1'b1, 50'h0} >> 0);
            end
        end
    endtask

    task automatic test_len1();
        int exp_ph[4] = '{0, 1, 0, 1};
        do_reset();
        el = 3'd1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (phase_a !== 2'(exp_ph[c]) || retire_a !== (c % 2 == 1) ||
                exec_a !== ((c % 2 == 1) ? 2'b01 : 2'b00) || fetch_a !== (c % 2 == 0)) begin
                failures++;
                $display("FAIL len1 cyc=%0d got phase=%0d retire=%b exec=%b want phase=%0d",
                         c, phase_a, retire_a, exec_a, exp_ph[c]);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL len1_model inst=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i));
                end
            end
            step();
        end
    endtask

    task automatic test_len2();
        int exp_ph[4] = '{0, 1, 2, 0};
        do_reset();
        el = 3'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (phase_a !== 2'(exp_ph[c]) || retire_a !== (c == 2)) begin
                failures++;
                $display("FAIL len2 cyc=%0d got phase=%0d retire=%b want phase=%0d retire=%b",
                         c, phase_a, retire_a, exp_ph[c], c == 2);
            end
            step();
        end
    endtask

    task automatic test_stall();
        int exp_ph[7] = '{0, 1, 2, 2, 2, 3, 0};
        int nret = 0;
        do_reset();
        el = 3'd3;
        for (int c = 0; c < 7; c++) begin
            stl = (c == 2 || c == 3);
            #1;
            checks++;
            if (phase_b !== 3'(exp_ph[c])) begin
                failures++;
                $display("FAIL stall_phase cyc=%0d got=%0d want=%0d", c, phase_b, exp_ph[c]);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL stall_model inst=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i));
                end
            end
            if (retire_b) nret++;
            step();
        end
        stl = 1'b0;
        checks++;
        if (nret !== 1) begin
            failures++;
            $display("FAIL stall_retires got=%0d want=1", nret);
        end
    endtask

    task automatic test_clamp();
        int nexec;
        // exec_len 0 -> one execute cycle
        do_reset();
        el = 3'd0;
        nexec = 0;
        step();
        while (phase_b != 3'd0 && nexec < 10) begin nexec++; step(); end
        checks++;
        if (nexec !== 1) begin
            failures++;
            $display("FAIL clamp_zero got=%0d want=1", nexec);
        end
        // exec_len 7 -> EXEC_MAX (4) execute cycles
        do_reset();
        el = 3'd7;
        nexec = 0;
        step();
        while (phase_b != 3'd0 && nexec < 10) begin nexec++; step(); end
        checks++;
        if (nexec !== 4) begin
            failures++;
            $display("FAIL clamp_max got=%0d want=4", nexec);
        end
    endtask

    task automatic test_halt();
        logic [15:0] cyc_hold;
        do_reset();
        el = 3'd1;
        hreq = 1'b1;
        step();           // fetch
        step();           // retiring exec cycle samples halt_req
        hreq = 1'b0;
        #1;
        checks++;
        if (halted_b !== 1'b1 || phase_b !== 3'd5 || halted_a !== 1'b1 || phase_a !== 2'd3) begin
            failures++;
            $display("FAIL halt_enter got halted=%b/%b phase=%0d/%0d want 1/1 5/3",
                     halted_b, halted_a, phase_b, phase_a);
        end
        cyc_hold = 16'(cyc_b);
        stl = 1'b1;
        step(); step(); step();
        stl = 1'b0;
        #1;
        checks++;
`ifdef CPU_SEQ_PERF_COUNT_EN
        if (16'(cyc_b) !== cyc_hold || cyc_hold !== 16'(m_cyc[1])) begin
`else
        if (16'(cyc_b) !== 16'h0 || cyc_hold !== 16'h0) begin
`endif
            failures++;
            $display("FAIL halt_cycle_freeze got=%0d want=%0d", cyc_b, cyc_hold);
        end
        checks++;
        if (halted_b !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold got=%b want=1", halted_b);
        end
        res = 1'b1;
        step();
        res = 1'b0;
        #1;
        checks++;
        if (fetch_b !== 1'b1 || halted_b !== 1'b0 || phase_b !== 3'd0) begin
            failures++;
            $display("FAIL halt_resume got fetch=%b halted=%b want 1 0", fetch_b, halted_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        el = 3'd3;
        step(); step();
        #1;
        checks++;
        if (phase_b !== 3'd2) begin
            failures++;
            $display("FAIL reset_mid_setup got=%0d want=2", phase_b);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (fetch_b !== 1'b1 || phase_b !== 3'd0 || cyc_b !== 4'd0 || ins_b !== 4'd0 ||
            retire_b !== 1'b0 || exec_b !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid got fetch=%b phase=%0d cyc=%0d ins=%0d want 1 0 0 0",
                     fetch_b, phase_b, cyc_b, ins_b);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        el = 3'd1;
        for (int c = 0; c < 40; c++) step();
        #1;
        checks++;
`ifdef CPU_SEQ_PERF_COUNT_EN
        if (ins_b !== 4'd15 || cyc_b !== 4'd15 || ins_a !== 16'd20 || cyc_a !== 16'd40) begin
`else
        if (ins_b !== 4'd0 || cyc_b !== 4'd0 || ins_a !== 16'd0 || cyc_a !== 16'd0) begin
`endif
            failures++;
            $display("FAIL saturate got ins=%0d/%0d cyc=%0d/%0d", ins_b, ins_a, cyc_b, cyc_a);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            stl  = ($urandom_range(99, 0) < 30);
            hreq = ($urandom_range(99, 0) < 20);
            res  = ($urandom_range(99, 0) < 30);
            rst  = ($urandom_range(99, 0) < 2);
            el   = 3'($urandom_range(7, 0));
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL random cyc=%0d inst=%0d got=%h want=%h", c, i, obs_vec(i), exp_vec(i));
                end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_len1();
        test_len2();
        test_stall();
        test_clamp();
        test_halt();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cpu_sequencer
